// File: rtl/enigma_pkg.sv
// Shared types for the enigma message transmitter.
package enigma_pkg;

  localparam int unsigned SYMB_W = 7;
  localparam int unsigned NUMB_W = 8;
  localparam int unsigned GAP_W  = 4;

  typedef logic signed [SYMB_W-1:0] symbol_t;
  typedef logic [NUMB_W-1:0]        symb_numb_t;

  typedef enum logic [2:0] {
    IDLE,
    RRS,
    SEND,
    WAIT,
    DONE
  } tx_state_t;

endpackage

// File: rtl/enigma_symb_buf.sv
// Single-clock symbol buffer: FIFO-ordered write/read ports with occupancy count.
module enigma_symb_buf
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       wr_en_i,
  input  symbol_t    wr_data_i,
  input  logic       rd_en_i,
  output symbol_t    rd_data_o,
  output symb_numb_t count_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  symbol_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  symb_numb_t       count_q, count_d;
  logic             do_wr, do_rd;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == NUMB_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy update; clear returns the buffer to empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + NUMB_W'(do_wr) - NUMB_W'(do_rd);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/enigma_msg_tx.sv
// Message transmitter: buffers host symbols, then pulses rotor reset, streams
// the message to the encoder and counts returned results until done or timeout.
module enigma_msg_tx
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned GAP     = 0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_val_i,
  input  symbol_t    wr_symb_i,
  output logic       wr_rdy_o,
  input  logic       start_i,
  output logic       busy_o,
  output logic       rrs_rst_o,
  output logic       symb_val_o,
  output symb_numb_t symb_numb_o,
  output symbol_t    symbol_o,
  input  logic       res_val_i,
  output logic       done_o,
  output logic       err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  tx_state_t        state_q, state_d;
  symb_numb_t       res_cnt_q, res_cnt_d;
  symb_numb_t       sent_q, sent_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic       wr_rdy_q, wr_rdy_d;
  logic       busy_q, busy_d;
  logic       rrs_rst_q, rrs_rst_d;
  logic       symb_val_q, symb_val_d;
  symb_numb_t symb_numb_q, symb_numb_d;
  symbol_t    symbol_q, symbol_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       buf_clr, buf_rd, buf_full, buf_empty;
  symbol_t    buf_rd_data;
  symb_numb_t buf_count;

  logic       wr_acc, start_empty, timeout_hit, send_last;
  symb_numb_t cnt_after;

  enigma_symb_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (buf_clr),
    .wr_en_i   (wr_acc),
    .wr_data_i (wr_symb_i),
    .rd_en_i   (buf_rd),
    .rd_data_o (buf_rd_data),
    .count_o   (buf_count),
    .full_o    (buf_full),
    .empty_o   (buf_empty)
  );

  // A write is taken only while the registered ready is high.
  assign wr_acc      = wr_val_i && wr_rdy_q && !buf_full;
  assign cnt_after   = buf_count + NUMB_W'(wr_acc);
  assign start_empty = buf_empty && !wr_acc;
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign send_last   = (sent_q == symb_numb_q);

  // Returned-result counter, live in SEND/WAIT, saturating at the message length.
  always_comb begin
    res_cnt_d = res_cnt_q;
    if (state_q == RRS) begin
      res_cnt_d = '0;
    end else if ((state_q == SEND || state_q == WAIT) && res_val_i &&
                 (res_cnt_q != symb_numb_q)) begin
      res_cnt_d = res_cnt_q + NUMB_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; the current-cycle result strobe counts toward completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !start_empty) state_d = RRS;
      RRS:     state_d = SEND;
      SEND:    if (send_last) state_d = WAIT;
      WAIT: begin
        if (res_cnt_d == symb_numb_q) state_d = DONE;
        else if (timeout_hit)         state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath decode; outputs are loaded for the state being entered.
  always_comb begin
    buf_clr     = 1'b0;
    buf_rd      = 1'b0;
    sent_d      = sent_q;
    gap_d       = gap_q;
    to_cnt_d    = to_cnt_q;
    wr_rdy_d    = (state_d == IDLE) &&
                  ((state_q != IDLE) || (cnt_after < NUMB_W'(DEPTH)));
    busy_d      = (state_d != IDLE);
    rrs_rst_d   = (state_q == IDLE) && (state_d == RRS);
    symb_val_d  = 1'b0;
    symbol_d    = symbol_q;
    symb_numb_d = symb_numb_q;
    done_d      = (state_q == WAIT) && (state_d == DONE);
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = start_i && start_empty;
        if (state_d == RRS) symb_numb_d = cnt_after;
      end
      RRS: begin
        buf_rd     = 1'b1;
        symb_val_d = 1'b1;
        symbol_d   = buf_rd_data;
        sent_d     = NUMB_W'(1);
        gap_d      = GAP_W'(GAP);
        to_cnt_d   = '0;
      end
      SEND: begin
        if (state_d == SEND) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end else begin
            buf_rd     = 1'b1;
            symb_val_d = 1'b1;
            symbol_d   = buf_rd_data;
            sent_d     = sent_q + NUMB_W'(1);
            gap_d      = GAP_W'(GAP);
          end
        end
      end
      WAIT: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (state_d == IDLE) begin
          err_d   = 1'b1;
          buf_clr = 1'b1;
        end
      end
      DONE:    buf_clr = 1'b1;
      default: buf_clr = 1'b0;
    endcase
  end

  // Counter and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_cnt_q   <= '0;
      sent_q      <= '0;
      gap_q       <= '0;
      to_cnt_q    <= '0;
      wr_rdy_q    <= 1'b1;
      busy_q      <= 1'b0;
      rrs_rst_q   <= 1'b0;
      symb_val_q  <= 1'b0;
      symb_numb_q <= '0;
      symbol_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_cnt_q   <= res_cnt_d;
      sent_q      <= sent_d;
      gap_q       <= gap_d;
      to_cnt_q    <= to_cnt_d;
      wr_rdy_q    <= wr_rdy_d;
      busy_q      <= busy_d;
      rrs_rst_q   <= rrs_rst_d;
      symb_val_q  <= symb_val_d;
      symb_numb_q <= symb_numb_d;
      symbol_q    <= symbol_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign wr_rdy_o    = wr_rdy_q;
  assign busy_o      = busy_q;
  assign rrs_rst_o   = rrs_rst_q;
  assign symb_val_o  = symb_val_q;
  assign symb_numb_o = symb_numb_q;
  assign symbol_o    = symbol_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_enigma_msg_tx.sv
// Bench for enigma_msg_tx: two instances (GAP=0 and GAP=2) with a symbol scoreboard.
module tb_enigma_msg_tx;
  import enigma_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int          GAP0    = 0;
  localparam int          GAP1    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, wr_val, start, res_val;
  symbol_t    wr_symb [2];
  logic [1:0] wr_rdy, busy, rrs_rst, symb_val, done, err;
  symb_numb_t numb [2];
  symbol_t    sym [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mcount [2];
  int exp_numb [2];
  int sv_cnt [2];
  int last_cyc [2];
  symbol_t exp_q0 [$];
  symbol_t exp_q1 [$];

  enigma_msg_tx #(.DEPTH(DEPTH), .GAP(GAP0), .TIMEOUT(TIMEOUT)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst[0]), .wr_val_i(wr_val[0]), .wr_symb_i(wr_symb[0]),
    .wr_rdy_o(wr_rdy[0]), .start_i(start[0]), .busy_o(busy[0]),
    .rrs_rst_o(rrs_rst[0]), .symb_val_o(symb_val[0]), .symb_numb_o(numb[0]),
    .symbol_o(sym[0]), .res_val_i(res_val[0]), .done_o(done[0]), .err_o(err[0])
  );

  enigma_msg_tx #(.DEPTH(DEPTH), .GAP(GAP1), .TIMEOUT(TIMEOUT)) u_dut_g2 (
    .clk_i(clk), .rst_i(rst[1]), .wr_val_i(wr_val[1]), .wr_symb_i(wr_symb[1]),
    .wr_rdy_o(wr_rdy[1]), .start_i(start[1]), .busy_o(busy[1]),
    .rrs_rst_o(rrs_rst[1]), .symb_val_o(symb_val[1]), .symb_numb_o(numb[1]),
    .symbol_o(sym[1]), .res_val_i(res_val[1]), .done_o(done[1]), .err_o(err[1])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int d);
    return (d == 0) ? GAP0 : GAP1;
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void sb_push(input int d, input symbol_t v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endfunction

  function automatic symbol_t sb_pop(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Output monitor, 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rrs_rst[d]) sv_cnt[d] = 0;
      if (symb_val[d]) begin
        if (sb_size(d) == 0) begin
          check_eq($sformatf("sb_underflow[%0d]", d), sb_size(d), 1);
        end else begin
          check_eq($sformatf("symbol[%0d]", d), int'(sym[d]), int'(sb_pop(d)));
        end
        check_eq($sformatf("symb_numb[%0d]", d), int'(numb[d]), exp_numb[d]);
        if (sv_cnt[d] > 0)
          check_eq($sformatf("spacing[%0d]", d), cyc - last_cyc[d], gap_of(d) + 1);
        sv_cnt[d]++;
        last_cyc[d] = cyc;
      end
      if (done[d] || err[d])
        check_eq($sformatf("done_err_excl[%0d]", d), int'(done[d] & err[d]), 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input int d, input string tag);
    check_eq({tag, "_wr_rdy"}, int'(wr_rdy[d]), 1);
    check_eq({tag, "_busy"}, int'(busy[d]), 0);
    check_eq({tag, "_rrs"}, int'(rrs_rst[d]), 0);
    check_eq({tag, "_symb_val"}, int'(symb_val[d]), 0);
    check_eq({tag, "_numb"}, int'(numb[d]), 0);
    check_eq({tag, "_symbol"}, int'(sym[d]), 0);
    check_eq({tag, "_done"}, int'(done[d]), 0);
    check_eq({tag, "_err"}, int'(err[d]), 0);
  endtask

  task automatic write_sym(input int d, input int v);
    symbol_t s;
    s = SYMB_W'(v);
    check_eq($sformatf("wr_rdy[%0d]", d), int'(wr_rdy[d]), int'(mcount[d] < int'(DEPTH)));
    wr_val[d]  = 1'b1;
    wr_symb[d] = s;
    if (mcount[d] < int'(DEPTH)) begin
      sb_push(d, s);
      mcount[d]++;
    end
    tick();
    wr_val[d] = 1'b0;
  endtask

  task automatic start_msg(input int d, input bit do_wr, input int v);
    symbol_t s;
    s = SYMB_W'(v);
    start[d] = 1'b1;
    if (do_wr) begin
      wr_val[d]  = 1'b1;
      wr_symb[d] = s;
      sb_push(d, s);
      mcount[d]++;
    end
    exp_numb[d] = mcount[d];
    tick();
    start[d]  = 1'b0;
    wr_val[d] = 1'b0;
    check_eq("rrs_pulse", int'(rrs_rst[d]), 1);
    check_eq("rrs_busy", int'(busy[d]), 1);
    check_eq("rrs_numb", int'(numb[d]), exp_numb[d]);
    check_eq("rrs_wr_rdy", int'(wr_rdy[d]), 0);
    check_eq("rrs_no_symb", int'(symb_val[d]), 0);
    tick();
    check_eq("rrs_single", int'(rrs_rst[d]), 0);
    check_eq("first_symb", int'(symb_val[d]), 1);
    mcount[d] = 0;
  endtask

  task automatic wait_sent(input int d, input int n);
    int guard = 0;
    while (sv_cnt[d] < n && guard < 200) begin
      tick();
      guard++;
    end
    check_eq("sent_count", sv_cnt[d], n);
  endtask

  task automatic pulse_res(input int d, input int k);
    for (int i = 0; i < k; i++) begin
      res_val[d] = 1'b1;
      tick();
    end
    res_val[d] = 1'b0;
  endtask

  task automatic expect_done(input int d);
    check_eq("done_pulse", int'(done[d]), 1);
    check_eq("done_no_err", int'(err[d]), 0);
    check_eq("done_busy", int'(busy[d]), 1);
    tick();
    check_eq("done_single", int'(done[d]), 0);
    check_eq("idle_busy", int'(busy[d]), 0);
    check_eq("idle_wr_rdy", int'(wr_rdy[d]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11; wr_val = '0; start = '0; res_val = '0;
    wr_symb[0] = '0; wr_symb[1] = '0;
    mcount[0] = 0; mcount[1] = 0;
    tick(); tick();
    rst = 2'b00;
    check_reset_outs(0, "rst0");
    check_reset_outs(1, "rst1");

    // Three-symbol message, GAP=0, results after the stream.
    write_sym(0, 5); write_sym(0, -12); write_sym(0, 63);
    start_msg(0, 1'b0, 0);
    wait_sent(0, 3);
    pulse_res(0, 3);
    expect_done(0);

    // Start with an empty buffer.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check_eq("empty_err", int'(err[0]), 1);
    check_eq("empty_no_rrs", int'(rrs_rst[0]), 0);
    check_eq("empty_busy", int'(busy[0]), 0);
    tick();
    check_eq("empty_err_single", int'(err[0]), 0);
    check_eq("empty_busy2", int'(busy[0]), 0);
    check_eq("empty_no_rrs2", int'(rrs_rst[0]), 0);

    // Fill to DEPTH, one extra write must be dropped.
    for (int i = 0; i < int'(DEPTH); i++) write_sym(0, int'($urandom_range(0, 127)) - 64);
    write_sym(0, 33);
    start_msg(0, 1'b0, 0);
    wait_sent(0, int'(DEPTH));
    pulse_res(0, int'(DEPTH));
    expect_done(0);

    // GAP=2 instance, results arrive during SEND.
    write_sym(1, -1); write_sym(1, 42);
    start_msg(1, 1'b0, 0);
    pulse_res(1, 2);
    wait_sent(1, 2);
    check_eq("gap_done_early0", int'(done[1]), 0);
    tick();
    check_eq("gap_done_early1", int'(done[1]), 0);
    check_eq("gap_wait_busy", int'(busy[1]), 1);
    tick();
    expect_done(1);

    // Timeout: one result of three.
    write_sym(0, 10); write_sym(0, -20); write_sym(0, 30);
    start_msg(0, 1'b0, 0);
    wait_sent(0, 3);
    pulse_res(0, 1);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      check_eq("to_no_err", int'(err[0]), 0);
      check_eq("to_no_done", int'(done[0]), 0);
      check_eq("to_busy", int'(busy[0]), 1);
      tick();
    end
    check_eq("to_err", int'(err[0]), 1);
    check_eq("to_err_no_done", int'(done[0]), 0);
    check_eq("to_idle", int'(busy[0]), 0);
    check_eq("to_wr_rdy", int'(wr_rdy[0]), 1);
    tick();
    check_eq("to_err_single", int'(err[0]), 0);
    write_sym(0, -64); write_sym(0, 1);
    start_msg(0, 1'b0, 0);
    wait_sent(0, 2);
    pulse_res(0, 2);
    expect_done(0);

    // Reset in the middle of SEND, then a start with a same-cycle write.
    write_sym(0, 1); write_sym(0, 2); write_sym(0, 3); write_sym(0, 4);
    start_msg(0, 1'b0, 0);
    rst[0] = 1'b1;
    tick();
    check_reset_outs(0, "midrst");
    exp_q0.delete();
    mcount[0] = 0;
    rst[0] = 1'b0;
    write_sym(0, 7); write_sym(0, 8);
    start_msg(0, 1'b1, 9);
    wait_sent(0, 3);
    pulse_res(0, 3);
    expect_done(0);

    tick();
    check_eq("sb_leftover", sb_size(0) + sb_size(1), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
